// File: rtl/spi_master_if.sv
// Parallel command side and serial pins of the SPI master.
// The master modport is the controller's view; the slave modport is the
// host/peer view driving commands and MISO.
interface spi_master_if #(
  parameter int unsigned MEM_WIDTH = 8
);
  logic                 start;
  logic [1:0]           cmd;
  logic [MEM_WIDTH-1:0] payload;
  logic                 busy;
  logic                 done;
  logic [MEM_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;

  modport master (
    input  start, cmd, payload, MISO,
    output busy, done, rd_data, rd_valid, SS_n, MOSI
  );

  modport slave (
    output start, cmd, payload, MISO,
    input  busy, done, rd_data, rd_valid, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// SPI master: serializes a {cmd, payload} frame MSB first under SS_n and,
// for read-data commands, captures the reply byte from MISO after a
// configurable turnaround. Serial clock is the system clock.
// Every pin is a register computed from the current state, so pins trail
// the state register by one cycle; RECV sampling is aligned to that lag.
module spi_master #(
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input logic          clk,
  input logic          rst_n,
  spi_master_if.master bus
);

  localparam int unsigned FrameW = MEM_WIDTH + 2;

  localparam logic [3:0] ShiftLast = 4'(FrameW - 1);
  localparam logic [3:0] TurnLast  = 4'(RD_LATENCY - 1);
  localparam logic [3:0] RecvLast  = 4'(MEM_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StCmdBit,
    StShift,
    StTurn,
    StRecv,
    StEnd
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [FrameW-1:0]    frame_q, frame_d;
  logic                 is_rd_q, is_rd_d;
  logic [MEM_WIDTH-1:0] rx_q, rx_d;

  logic                 ss_n_q, ss_n_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [MEM_WIDTH-1:0] rd_data_q, rd_data_d;

  // Next state, frame shift register and MISO capture
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    is_rd_d = is_rd_q;
    rx_d    = rx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSelect;
          frame_d = {bus.cmd, bus.payload};
          is_rd_d = (bus.cmd == 2'b11);
        end
      end
      StSelect: state_d = StCmdBit;
      // The command MSB goes out here to steer the slave, then the whole
      // frame (including that bit again) follows in SHIFT.
      StCmdBit: state_d = StShift;
      StShift: begin
        frame_d = {frame_q[FrameW-2:0], 1'b0};
        if (cnt_q == ShiftLast) begin
          state_d = is_rd_q ? StTurn : StEnd;
        end
      end
      StTurn: begin
        if (cnt_q == TurnLast) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        rx_d = {rx_q[MEM_WIDTH-2:0], bus.MISO};
        if (cnt_q == RecvLast) begin
          state_d = StEnd;
        end
      end
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bit counter: clears on every state entry, counts only in multi-cycle states
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == StShift || state_q == StTurn || state_q == StRecv)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Pin values decoded from the current state, registered below
  always_comb begin
    ss_n_d     = (state_q == StIdle) || (state_q == StEnd);
    mosi_d     = (state_q == StCmdBit || state_q == StShift) ? frame_q[FrameW-1] : 1'b0;
    busy_d     = (state_q != StIdle);
    done_d     = (state_q == StEnd);
    rd_valid_d = (state_q == StEnd) && is_rd_q;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = rx_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      frame_q <= '0;
      is_rd_q <= 1'b0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      is_rd_q <= is_rd_d;
      rx_q    <= rx_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + RAM peer.
module tb_spi_master;

  localparam int RdLat = 2;

  logic clk;
  logic rst_n;

  spi_master_if #(.MEM_WIDTH(8)) bus ();

  spi_master #(
    .MEM_WIDTH (8),
    .RD_LATENCY(RdLat)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Peer model state and per-frame records
  int          idx = 0;
  int          high_run = 0;
  logic [11:0] log_cur = '0;
  logic [7:0]  mem [256];
  logic [7:0]  wr_addr = '0;
  logic [7:0]  rd_addr = '0;
  logic [7:0]  reply = '0;
  logic        rd_frame = 1'b0;
  logic [11:0] logs [$];
  int          lens [$];
  int          gaps [$];
  int          done_cnt = 0;
  int          rv_cnt = 0;
  int          rv_orphan = 0;
  logic [7:0]  rv_data = '0;

  // Slave + RAM peer: decode the frame from MOSI, answer read-data on MISO
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.rd_valid) begin
      rv_cnt++;
      rv_data = bus.rd_data;
      if (!bus.done) rv_orphan++;
    end
    if (!bus.SS_n) begin
      if (idx == 0) begin
        gaps.push_back(high_run);
        log_cur = '0;
      end
      high_run = 0;
      if (idx < 12) log_cur[11-idx] = bus.MOSI;
      if (idx == 11) begin
        case (log_cur[9:8])
          2'b00: wr_addr = log_cur[7:0];
          2'b01: mem[wr_addr] = log_cur[7:0];
          2'b10: rd_addr = log_cur[7:0];
          default: begin
            reply    = mem[rd_addr];
            rd_frame = 1'b1;
          end
        endcase
      end
      if (rd_frame && idx >= 11 + RdLat && idx < 19 + RdLat) bus.MISO = reply[7-(idx-11-RdLat)];
      else bus.MISO = 1'b0;
      idx++;
    end else begin
      if (idx != 0) begin
        logs.push_back(log_cur);
        lens.push_back(idx);
      end
      idx = 0;
      high_run++;
      rd_frame = 1'b0;
      bus.MISO = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one frame; reports done latency (negedges after the accept edge)
  task automatic run_frame(input logic [1:0] c, input logic [7:0] p, input int repulse_at,
                           output int lat, output logic s0, output logic s1,
                           output logic b0, output logic b1);
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = c; bus.payload = p;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1; s0 = 1'bx; s1 = 1'bx; b0 = 1'bx; b1 = 1'bx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == repulse_at) begin
        bus.start = 1'b1; bus.cmd = 2'b01; bus.payload = 8'hFF;
      end else if (k == repulse_at + 1) begin
        bus.start = 1'b0; bus.cmd = c; bus.payload = p;
      end
      if (k == 0) begin s0 = bus.SS_n; b0 = bus.busy; end
      if (k == 1) begin s1 = bus.SS_n; b1 = bus.busy; end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [11:0] exp_log, input int exp_len);
    check({tag, "_mosi"}, 32'(logs[logs.size()-1]), 32'(exp_log));
    check({tag, "_ss_low"}, lens[lens.size()-1], exp_len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, d, r, n, sz;
    logic s0, s1, b0, b1;

    rst_n = 1'b1;
    bus.start = 1'b0; bus.cmd = 2'b00; bus.payload = 8'h00;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ss_n", bus.SS_n, 1);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write-addr 0x3A
    d = done_cnt; r = rv_cnt;
    run_frame(2'b00, 8'h3A, -10, lat, s0, s1, b0, b1);
    check("wa_ss_high_at_T", s0, 1);
    check("wa_ss_low_at_T+1", s1, 0);
    check("wa_busy_low_at_T", b0, 0);
    check("wa_busy_high_at_T+1", b1, 1);
    check("wa_done_latency", lat, 13);
    check_frame("wa", 12'h03A, 12);
    check("wa_done_count", done_cnt - d, 1);
    check("wa_rv_count", rv_cnt - r, 0);

    // Write-data 0xA5 with a start re-pulse (01/0xFF) while busy
    repeat (3) @(posedge clk);
    d = done_cnt; n = logs.size();
    run_frame(2'b01, 8'hA5, 4, lat, s0, s1, b0, b1);
    check("wd_done_latency", lat, 13);
    check_frame("wd", 12'h1A5, 12);
    repeat (20) @(posedge clk);
    #1;
    check("repulse_done_count", done_cnt - d, 1);
    check("repulse_frame_count", logs.size() - n, 1);
    check("repulse_busy_idle", bus.busy, 0);

    // Read-addr 0x3A, then read-data: peer replies 0xA5
    run_frame(2'b10, 8'h3A, -10, lat, s0, s1, b0, b1);
    check("ra_done_latency", lat, 13);
    check_frame("ra", 12'h63A, 12);
    repeat (3) @(posedge clk);
    d = done_cnt; r = rv_cnt;
    run_frame(2'b11, 8'h00, -10, lat, s0, s1, b0, b1);
    check("rd_done_latency", lat, 23);
    check_frame("rd", 12'h700, 22);
    check("rd_rv_count", rv_cnt - r, 1);
    check("rd_done_count", done_cnt - d, 1);
    check("rd_rv_data", rv_data, 8'hA5);
    check("rd_data_hold", bus.rd_data, 8'hA5);
    check("rd_rv_without_done", rv_orphan, 0);

    // Back-to-back write-data 0x55 then read-addr 0x10 with start held high
    repeat (3) @(posedge clk);
    d = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b01; bus.payload = 8'h55;
    @(posedge clk);
    #1 bus.cmd = 2'b10; bus.payload = 8'h10;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (k == 13) bus.start = 1'b0;
      if (done_cnt - d >= 2) break;
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    sz = logs.size();
    check("b2b_done_count", done_cnt - d, 2);
    check("b2b_first_mosi", 32'(logs[sz-2]), 32'h155);
    check("b2b_first_ss_low", lens[sz-2], 12);
    check("b2b_second_mosi", 32'(logs[sz-1]), 32'h610);
    check("b2b_second_ss_low", lens[sz-1], 12);
    check("b2b_ss_high_gap", gaps[gaps.size()-1], 2);
    check("b2b_rd_data_hold", bus.rd_data, 8'hA5);

    // End-to-end through the RAM model: 0xC3 stored at 0x07 and read back
    repeat (3) @(posedge clk);
    run_frame(2'b00, 8'h07, -10, lat, s0, s1, b0, b1);
    repeat (3) @(posedge clk);
    run_frame(2'b01, 8'hC3, -10, lat, s0, s1, b0, b1);
    repeat (3) @(posedge clk);
    run_frame(2'b10, 8'h07, -10, lat, s0, s1, b0, b1);
    repeat (3) @(posedge clk);
    r = rv_cnt;
    run_frame(2'b11, 8'h5A, -10, lat, s0, s1, b0, b1);
    check("e2e_done_latency", lat, 23);
    check("e2e_rv_count", rv_cnt - r, 1);
    check("e2e_rv_data", rv_data, 8'hC3);
    check("e2e_rd_data", bus.rd_data, 8'hC3);

    // Asynchronous reset in the middle of SHIFT while MOSI is high
    repeat (3) @(posedge clk);
    d = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = 2'b00; bus.payload = 8'hFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_ss_low", bus.SS_n, 0);
    check("pre_rst_mosi_high", bus.MOSI, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", bus.SS_n, 1);
    check("mid_rst_mosi", bus.MOSI, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rd_data", bus.rd_data, 0);
    check("mid_rst_done", bus.done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_no_done", done_cnt - d, 0);
    check("post_rst_ss_n", bus.SS_n, 1);
    check("post_rst_busy", bus.busy, 0);

    // Fresh frame after reset: write-addr 0x81
    run_frame(2'b00, 8'h81, -10, lat, s0, s1, b0, b1);
    check("post_rst_done_latency", lat, 13);
    check_frame("post_rst", 12'h081, 12);
    check("post_rst_rd_data", bus.rd_data, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
